// File: rtl/bpsk_rx.sv
// bpsk_rx: BPSK integrate-and-dump demodulator with a preamble-locked fixed-length framer.
// Optional feature macro BPSK_RX_INV_DETECT_EN: also lock on ~PREAMBLE and correct payload polarity.
module bpsk_rx #(
    parameter int unsigned SAMPLES_PER_SYM = 32,
    parameter logic [7:0]  PREAMBLE        = 8'hA5,
    parameter int unsigned FRAME_BITS      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sample_vld,
    input  logic signed [15:0] sample_in,
    output logic               bit_out,
    output logic               bit_vld,
    output logic               locked,
    output logic               inverted,
    output logic               frame_done,
    output logic [1:0]         dbg_state_o
);

    localparam int unsigned PW       = $clog2(SAMPLES_PER_SYM);
    localparam int unsigned ACC_W    = 16 + PW + 1;
    localparam logic [7:0]  LAST_BIT = 8'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                   state_q;
    logic [PW-1:0]            phase_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [7:0]               sync_q;
    logic [7:0]               bitcnt_q;
    logic                     pol_q;
    logic                     bit_out_q;
    logic                     bit_vld_q;
    logic                     frame_done_q;
    logic                     locked_q;
    logic                     inverted_q;

    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  contrib;
    logic signed [ACC_W-1:0]  sum_d;
    logic                     last_phase;
    logic                     decision;
    logic [7:0]               sync_d;
    logic                     pre_match;
    logic                     inv_match;

    // sample_vld is a pure qualifier with no ready: every qualified sample is consumed in its cycle.
    // Sign-extending before negation keeps -(-32768) representable in the wider accumulator.
    always_comb begin
        sample_ext = {{(ACC_W-16){sample_in[15]}}, sample_in};
        contrib    = phase_q[PW-1] ? -sample_ext : sample_ext;
        sum_d      = (phase_q == '0) ? contrib : acc_q + contrib;
        last_phase = &phase_q;
        decision   = (sum_d > 0);
        sync_d     = {sync_q[6:0], decision};
        pre_match  = (sync_d == PREAMBLE);
`ifdef BPSK_RX_INV_DETECT_EN
        inv_match  = (sync_d == ~PREAMBLE);
`else
        inv_match  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            acc_q        <= '0;
            sync_q       <= '0;
            bitcnt_q     <= '0;
            pol_q        <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            inverted_q   <= 1'b0;
        end else begin
            bit_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (!en) begin
                state_q    <= ST_IDLE;
                phase_q    <= '0;
                acc_q      <= '0;
                sync_q     <= '0;
                bitcnt_q   <= '0;
                pol_q      <= 1'b0;
                locked_q   <= 1'b0;
                inverted_q <= 1'b0;
            end else begin
                // Holding locked from the current state makes it fall one cycle after frame_done.
                locked_q <= (state_q == ST_DATA);
                case (state_q)
                    ST_IDLE: state_q <= ST_SYNC;
                    ST_SYNC: begin
                        if (sample_vld) begin
                            phase_q <= phase_q + PW'(1);
                            acc_q   <= sum_d;
                            if (last_phase) begin
                                sync_q <= sync_d;
                                if (pre_match || inv_match) begin
                                    state_q    <= ST_DATA;
                                    locked_q   <= 1'b1;
                                    pol_q      <= !pre_match;
                                    inverted_q <= !pre_match;
                                    bitcnt_q   <= '0;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sample_vld) begin
                            phase_q <= phase_q + PW'(1);
                            acc_q   <= sum_d;
                            if (last_phase) begin
                                bit_out_q <= decision ^ pol_q;
                                bit_vld_q <= 1'b1;
                                if (bitcnt_q == LAST_BIT) begin
                                    frame_done_q <= 1'b1;
                                    state_q      <= ST_SYNC;
                                    sync_q       <= '0;
                                    pol_q        <= 1'b0;
                                    bitcnt_q     <= '0;
                                end else begin
                                    bitcnt_q <= bitcnt_q + 8'd1;
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_vld     = bit_vld_q;
    assign locked      = locked_q;
    assign inverted    = inverted_q;
    assign frame_done  = frame_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bpsk_rx.sv
// tb_bpsk_rx: randomized stimulus for bpsk_rx checked against an arithmetic symbol/framing model.
// Expectations follow BPSK_RX_INV_DETECT_EN when it is defined for the build.
module tb_bpsk_rx;

    localparam int N  = 32;
    localparam int FB = 16;
    localparam logic [7:0] PRE = 8'hA5;
`ifdef BPSK_RX_INV_DETECT_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sample_vld;
    logic [15:0] sample_in;
    logic        bit_out, bit_vld, locked, inverted, frame_done;
    logic [1:0]  dbg_state;

    bpsk_rx #(.SAMPLES_PER_SYM(N), .PREAMBLE(PRE), .FRAME_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sample_vld(sample_vld), .sample_in(sample_in),
        .bit_out(bit_out), .bit_vld(bit_vld), .locked(locked), .inverted(inverted),
        .frame_done(frame_done), .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // stimulus and model storage
    int samp_q[$];
    int end_cyc_q[$];
    bit exp_bit_q[$];
    bit exp_fd_q[$];
    bit exp_inv_q[$];
    int exp_sym_q[$];

    // captured DUT strobes
    bit got_bit_q[$];
    bit got_fd_q[$];
    bit got_inv_q[$];
    int got_cyc_q[$];
    int fd_count, lock_cyc, unlock_cyc, fd_cyc;
    bit saw_lock, locked_prev;

    always @(negedge clk) begin
        if (bit_vld) begin
            got_bit_q.push_back(bit_out);
            got_fd_q.push_back(frame_done);
            got_inv_q.push_back(inverted);
            got_cyc_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        if (locked && !locked_prev) lock_cyc = cyc;
        if (!locked && locked_prev) unlock_cyc = cyc;
        if (locked) saw_lock = 1'b1;
        locked_prev = locked;
    end

    task automatic clear_capture();
        got_bit_q.delete(); got_fd_q.delete(); got_inv_q.delete(); got_cyc_q.delete();
        fd_count = 0; lock_cyc = -1; unlock_cyc = -1; fd_cyc = -1; saw_lock = 1'b0;
        samp_q.delete();
    endtask

    // driver tasks
    task automatic start_stream();
        en = 1'b0; sample_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_capture();
    endtask

    task automatic push_symbol(input bit b);
        int amp, v;
        amp = int'($urandom_range(500, 3000));
        for (int p = 0; p < N; p++) begin
            v = amp + int'($urandom_range(0, 400)) - 200;
            if ((p < N/2) != b) v = -v;
            samp_q.push_back(v);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input int nb);
        for (int i = nb - 1; i >= 0; i--) push_symbol(w[i]);
    endtask

    task automatic run_stream(input bit gaps, input bit kill_last);
        int g;
        end_cyc_q.delete();
        for (int i = 0; i < samp_q.size(); i++) begin
            if (gaps) begin
                g = 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
                repeat (g) begin
                    @(posedge clk); #1;
                    sample_vld = 1'b0;
                    sample_in  = 16'($urandom);
                end
            end
            @(posedge clk); #1;
            sample_vld = 1'b1;
            sample_in  = 16'(samp_q[i]);
            if (kill_last && i == samp_q.size() - 1) en = 1'b0;
            if (i % N == N - 1) end_cyc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        sample_vld = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // reference model: per-symbol correlation sums, then preamble search over the decision stream
    task automatic model_run();
        logic [7:0] win;
        bit in_frame, pol, d;
        int cnt, sum;
        win = 8'h00; in_frame = 1'b0; pol = 1'b0; cnt = 0;
        exp_bit_q.delete(); exp_fd_q.delete(); exp_inv_q.delete(); exp_sym_q.delete();
        for (int s = 0; s < samp_q.size() / N; s++) begin
            sum = 0;
            for (int p = 0; p < N; p++)
                sum += (p < N/2) ? samp_q[s*N+p] : -samp_q[s*N+p];
            d = (sum > 0);
            if (in_frame) begin
                exp_bit_q.push_back(d ^ pol);
                exp_fd_q.push_back(cnt == FB - 1);
                exp_inv_q.push_back(pol);
                exp_sym_q.push_back(s);
                cnt++;
                if (cnt == FB) begin
                    in_frame = 1'b0; win = 8'h00; pol = 1'b0;
                end
            end else begin
                win = {win[6:0], d};
                if (win == PRE) begin
                    in_frame = 1'b1; cnt = 0; pol = 1'b0;
                end else if (INV_EN && win == ~PRE) begin
                    in_frame = 1'b1; cnt = 0; pol = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bit_out, bit_vld, locked, inverted, frame_done, dbg_state} !== 7'b0)
            $display("FAIL reset_values got %b exp 0000000", {bit_out, bit_vld, locked, inverted, frame_done, dbg_state});
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        start_stream();
        push_word({8'h00, PRE}, 8);
        push_word(16'h0005, 3);
        for (int i = 0; i < 10; i++) samp_q.push_back(int'($urandom_range(0, 2000)) - 1000);
        run_stream(1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL reset_prelock got %b exp 1", locked);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bit_out, bit_vld, locked, inverted, frame_done, dbg_state} !== 7'b0)
            $display("FAIL reset_async got %b exp 0000000", {bit_out, bit_vld, locked, inverted, frame_done, dbg_state});
        else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_capture();
        push_word(16'($urandom), 12);
        push_word({8'h00, PRE}, 8);
        push_word(16'($urandom), 16);
        run_stream(1'b0, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size())
            $display("FAIL reset_count got %0d exp %0d", got_bit_q.size(), exp_bit_q.size());
        else n_pass++;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i], got_inv_q[i]} !== {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}
                || got_cyc_q[i] != end_cyc_q[exp_sym_q[i]])
                $display("FAIL reset_strobe%0d got bit/fd/inv=%b cyc=%0d exp %b cyc=%0d", i,
                         {got_bit_q[i], got_fd_q[i], got_inv_q[i]}, got_cyc_q[i],
                         {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}, end_cyc_q[exp_sym_q[i]]);
            else n_pass++;
        end
    endtask

    task automatic test_normal_frame(input bit gaps, input string nm);
        logic [15:0] word;
        start_stream();
        push_word({8'h00, PRE}, 8);
        push_word(16'hC3F0, 16);
        run_stream(gaps, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size())
            $display("FAIL %s_count got %0d exp %0d", nm, got_bit_q.size(), exp_bit_q.size());
        else n_pass++;
        word = 16'h0;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            word = {word[14:0], got_bit_q[i]};
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i], got_inv_q[i]} !== {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}
                || got_cyc_q[i] != end_cyc_q[exp_sym_q[i]])
                $display("FAIL %s_strobe%0d got bit/fd/inv=%b cyc=%0d exp %b cyc=%0d", nm, i,
                         {got_bit_q[i], got_fd_q[i], got_inv_q[i]}, got_cyc_q[i],
                         {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}, end_cyc_q[exp_sym_q[i]]);
            else n_pass++;
        end
        n_checks++;
        if (word !== 16'hC3F0) $display("FAIL %s_payload got %h exp c3f0", nm, word);
        else n_pass++;
        n_checks++;
        if (lock_cyc != end_cyc_q[7]) $display("FAIL %s_lock_cycle got %0d exp %0d", nm, lock_cyc, end_cyc_q[7]);
        else n_pass++;
        n_checks++;
        if (fd_count != 1 || unlock_cyc != fd_cyc + 1)
            $display("FAIL %s_unlock got fd=%0d unlock=%0d exp fd=1 unlock=%0d", nm, fd_count, unlock_cyc, fd_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        start_stream();
        for (int f = 0; f < 2; f++) begin
            push_word({8'h00, PRE}, 8);
            push_word(16'($urandom), 16);
        end
        run_stream(1'b0, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size() || fd_count != 2)
            $display("FAIL b2b_count got %0d/%0d exp %0d/2", got_bit_q.size(), fd_count, exp_bit_q.size());
        else n_pass++;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i], got_inv_q[i]} !== {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}
                || got_cyc_q[i] != end_cyc_q[exp_sym_q[i]])
                $display("FAIL b2b_strobe%0d got bit/fd/inv=%b cyc=%0d exp %b cyc=%0d", i,
                         {got_bit_q[i], got_fd_q[i], got_inv_q[i]}, got_cyc_q[i],
                         {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]}, end_cyc_q[exp_sym_q[i]]);
            else n_pass++;
        end
    endtask

    task automatic test_inverted();
        logic [15:0] word;
        start_stream();
        push_word(16'h005A, 8);
        push_word(16'h3C0F, 16);
        run_stream(1'b0, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size())
            $display("FAIL inv_count got %0d exp %0d", got_bit_q.size(), exp_bit_q.size());
        else n_pass++;
        word = 16'h0;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            word = {word[14:0], got_bit_q[i]};
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i], got_inv_q[i]} !== {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]})
                $display("FAIL inv_strobe%0d got bit/fd/inv=%b exp %b", i,
                         {got_bit_q[i], got_fd_q[i], got_inv_q[i]}, {exp_bit_q[i], exp_fd_q[i], exp_inv_q[i]});
            else n_pass++;
        end
`ifdef BPSK_RX_INV_DETECT_EN
        n_checks++;
        if (word !== 16'hC3F0 || got_bit_q.size() != 16)
            $display("FAIL inv_payload got %h (%0d bits) exp c3f0 (16 bits)", word, got_bit_q.size());
        else n_pass++;
`else
        n_checks++;
        if (saw_lock || got_bit_q.size() != 0 || dbg_state !== 2'd1)
            $display("FAIL inv_no_lock got lock=%b strobes=%0d state=%0d exp 0 0 1", saw_lock, got_bit_q.size(), dbg_state);
        else n_pass++;
`endif
    endtask

    task automatic test_abort();
        int n_before;
        start_stream();
        push_word({8'h00, PRE}, 8);
        push_word(16'h0018, 5);
        for (int i = 0; i < 13; i++) samp_q.push_back(1000);
        run_stream(1'b0, 1'b0);
        n_checks++;
        if (got_bit_q.size() != 5 || {got_bit_q[0], got_bit_q[1], got_bit_q[2], got_bit_q[3], got_bit_q[4]} !== 5'b11000)
            $display("FAIL abort_first5 got %0d strobes exp 5 strobes 11000", got_bit_q.size());
        else n_pass++;
        #1 en = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (locked !== 1'b0 || dbg_state !== 2'd0) $display("FAIL abort_unlock got locked=%b state=%0d exp 0 0", locked, dbg_state);
        else n_pass++;
        n_before = got_bit_q.size();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            sample_vld = 1'($urandom);
            sample_in  = 16'($urandom);
        end
        sample_vld = 1'b0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (got_bit_q.size() != n_before || fd_count != 0)
            $display("FAIL abort_quiet got strobes=%0d fd=%0d exp %0d 0", got_bit_q.size(), fd_count, n_before);
        else n_pass++;
        start_stream();
        push_word({8'h00, PRE}, 8);
        push_word(16'hC3F0, 16);
        run_stream(1'b0, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size() || fd_count != 1)
            $display("FAIL abort_refill_count got %0d/%0d exp %0d/1", got_bit_q.size(), fd_count, exp_bit_q.size());
        else n_pass++;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i]} !== {exp_bit_q[i], exp_fd_q[i]} || got_cyc_q[i] != end_cyc_q[exp_sym_q[i]])
                $display("FAIL abort_strobe%0d got bit/fd=%b cyc=%0d exp %b cyc=%0d", i,
                         {got_bit_q[i], got_fd_q[i]}, got_cyc_q[i], {exp_bit_q[i], exp_fd_q[i]}, end_cyc_q[exp_sym_q[i]]);
            else n_pass++;
        end
    endtask

    task automatic test_en_race();
        start_stream();
        push_word({8'h00, PRE}, 8);
        push_word(16'h000F, 4);
        run_stream(1'b0, 1'b1);
        n_checks++;
        if (got_bit_q.size() != 3 || fd_count != 0 || locked !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL en_race got strobes=%0d fd=%0d locked=%b state=%0d exp 3 0 0 0",
                     got_bit_q.size(), fd_count, locked, dbg_state);
        else n_pass++;
    endtask

    task automatic test_arith_corners();
        start_stream();
        push_word({8'h00, PRE}, 8);
        for (int p = 0; p < N; p++) samp_q.push_back((p < N/2) ? -32768 : 32767);
        for (int p = 0; p < N; p++) samp_q.push_back(0);
        // first half nets +1 (eight +1, seven -1, one 0); second half nets 0
        for (int p = 0; p < N/2; p++) samp_q.push_back((p == 0) ? 0 : ((p <= 8) ? 1 : -1));
        for (int p = 0; p < N/2; p++) samp_q.push_back((p % 2 == 0) ? 1 : -1);
        push_word(16'($urandom), 13);
        run_stream(1'b0, 1'b0);
        model_run();
        n_checks++;
        if (got_bit_q.size() < 3 || {got_bit_q[0], got_bit_q[1], got_bit_q[2]} !== 3'b001)
            $display("FAIL arith_corners got %0d strobes exp first bits 001", got_bit_q.size());
        else n_pass++;
        n_checks++;
        if (got_bit_q.size() != exp_bit_q.size())
            $display("FAIL arith_count got %0d exp %0d", got_bit_q.size(), exp_bit_q.size());
        else n_pass++;
        for (int i = 0; i < exp_bit_q.size() && i < got_bit_q.size(); i++) begin
            n_checks++;
            if ({got_bit_q[i], got_fd_q[i]} !== {exp_bit_q[i], exp_fd_q[i]})
                $display("FAIL arith_strobe%0d got bit/fd=%b exp %b", i, {got_bit_q[i], got_fd_q[i]}, {exp_bit_q[i], exp_fd_q[i]});
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sample_vld = 1'b0; sample_in = 16'h0;
        locked_prev = 1'b0;
        clear_capture();
        test_reset();
        test_normal_frame(1'b0, "normal");
        test_back_to_back();
        test_inverted();
        test_normal_frame(1'b1, "stall");
        test_abort();
        test_en_race();
        test_arith_corners();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
